// File: rtl/mux_2_1_pkg.sv
// Shared VCPU-32 datapath constants used by the word-wide steering mux.
package mux_2_1_pkg;

  localparam int unsigned WORD_WIDTH = 32;

endpackage

// File: rtl/dff_r.sv
// Generic WIDTH-bit register with asynchronous active-low clear, shared by datapath stages.
module dff_r #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [0:WIDTH-1] d,
  output logic [0:WIDTH-1] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/mux_2_1.sv
// Word-wide 2-to-1 mux with output enable; disabled output is zero so OR-combined buses stay clean.
// REGISTERED=1 adds one pipeline flop with asynchronous clear on the output.
module mux_2_1
  import mux_2_1_pkg::*;
#(
  parameter int unsigned WIDTH      = WORD_WIDTH,
  parameter bit          REGISTERED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [0:WIDTH-1] a0,
  input  logic [0:WIDTH-1] a1,
  input  logic             sel,
  input  logic             enb,
  output logic [0:WIDTH-1] y
);

  logic [0:WIDTH-1] y_next;

  // Select with enable; enb=0 dominates sel and both data inputs.
  always_comb begin
    y_next = '0;
    if (enb) begin
      y_next = sel ? a1 : a0;
    end
  end

  generate
    if (REGISTERED) begin : g_reg
      dff_r #(
        .WIDTH(WIDTH)
      ) u_dff_r (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (y_next),
        .q    (y)
      );
    end else begin : g_comb
      // Clock and reset have no function in the combinational build.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign y = y_next;
    end
  endgenerate

endmodule

// File: tb/tb_mux_2_1.sv
// Directed checks of mux_2_1: combinational 32-bit, registered 32-bit, and 8-bit bit-ordering builds.
module tb_mux_2_1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Combinational 32-bit instance
  logic [0:31] c_a0, c_a1, c_y;
  logic        c_sel, c_enb;
  // Registered 32-bit instance
  logic [0:31] r_a0, r_a1, r_y;
  logic        r_sel, r_enb, rst_n;
  // Combinational 8-bit instance
  logic [0:7]  w_a0, w_a1, w_y;
  logic        w_sel, w_enb;

  mux_2_1 #(.WIDTH(32), .REGISTERED(1'b0)) u_comb (
    .clk(clk), .rst_n(rst_n), .a0(c_a0), .a1(c_a1), .sel(c_sel), .enb(c_enb), .y(c_y)
  );

  mux_2_1 #(.WIDTH(32), .REGISTERED(1'b1)) u_reg (
    .clk(clk), .rst_n(rst_n), .a0(r_a0), .a1(r_a1), .sel(r_sel), .enb(r_enb), .y(r_y)
  );

  mux_2_1 #(.WIDTH(8), .REGISTERED(1'b0)) u_w8 (
    .clk(clk), .rst_n(rst_n), .a0(w_a0), .a1(w_a1), .sel(w_sel), .enb(w_enb), .y(w_y)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    c_a0 = 32'h0001_0101; c_a1 = 32'h0002_0202; c_sel = 1'b0; c_enb = 1'b1;
    r_a0 = 32'h0; r_a1 = 32'h2222_2222; r_sel = 1'b1; r_enb = 1'b1;
    w_a0 = 8'h80; w_a1 = 8'h01; w_sel = 1'b0; w_enb = 1'b1;

    // Combinational select
    #1 check("comb_sel0", c_y, 32'h0001_0101);
    c_sel = 1'b1;
    #1 check("comb_sel1", c_y, 32'h0002_0202);

    // Disabled output is zero regardless of sel
    c_enb = 1'b0; c_a0 = 32'hFFFF_FFFF; c_a1 = 32'hA5A5_A5A5; c_sel = 1'b0;
    #1 check("comb_dis_sel0", c_y, 32'h0);
    c_sel = 1'b1;
    #1 check("comb_dis_sel1", c_y, 32'h0);
    c_enb = 1'b1;
    #1 check("comb_en_sel1", c_y, 32'hA5A5_A5A5);
    c_sel = 1'b0;
    #1 check("comb_all_ones", c_y, 32'hFFFF_FFFF);

    // Bit ordering: index 0 is the MSB, no reversal
    #1 check("w8_sel0", {24'h0, w_y}, 32'h80);
    check("w8_bit0_msb", {31'h0, w_y[0]}, 32'h1);
    w_sel = 1'b1;
    #1 check("w8_sel1", {24'h0, w_y}, 32'h01);
    check("w8_bit7_lsb", {31'h0, w_y[7]}, 32'h1);

    // Registered: first edge captures a1, then asynchronous clear mid-cycle
    @(posedge clk); #1;
    check("reg_first_capture", r_y, 32'h2222_2222);
    #2 rst_n = 1'b0;
    #1 check("reg_async_clear", r_y, 32'h0);
    repeat (2) @(posedge clk);
    #1 check("reg_hold_in_reset", r_y, 32'h0);

    // Release: value appears only after the next rising edge
    r_a0 = 32'h1234_5678; r_sel = 1'b0; r_enb = 1'b1;
    rst_n = 1'b1;
    #1 check("reg_not_before_edge", r_y, 32'h0);
    @(posedge clk); #1;
    check("reg_after_release", r_y, 32'h1234_5678);

    // Pipelined toggling: y lags sel by one cycle
    r_a0 = 32'h1111_1111; r_a1 = 32'h2222_2222;
    begin
      logic [31:0] prev;
      logic [31:0] exp;
      prev = 32'h1234_5678;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        r_sel = i[0];
        exp = i[0] ? 32'h2222_2222 : 32'h1111_1111;
        #1 check("reg_lag_hold", r_y, prev);
        @(posedge clk); #1;
        check("reg_lag_update", r_y, exp);
        prev = exp;
      end
    end

    // Registered enable low captures zero
    @(negedge clk);
    r_enb = 1'b0; r_sel = 1'b1;
    @(posedge clk); #1;
    check("reg_disabled", r_y, 32'h0);

    // Mid-operation reset discards the captured value
    @(negedge clk);
    r_enb = 1'b1;
    @(posedge clk); #1;
    check("reg_before_midreset", r_y, 32'h2222_2222);
    #2 rst_n = 1'b0;
    #1 check("reg_midcycle_reset", r_y, 32'h0);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
